uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that feeds whole messages from NUM_REQ requesters to a single UART transmitter.
// Define UART_TX_SCHED_CRLF_EN to append CR/LF after each message's last byte (adds the TERM state).
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                            CLK,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
  input  logic                            uart_tx_busy,
  output logic [2:0]                      grant_id,
  output logic                            sched_busy
);

`ifdef UART_TX_SCHED_CRLF_EN
  typedef enum logic [2:0] {IDLE, FETCH, START, WAIT_ACK, WAIT_DONE, TERM} state_t;
  localparam logic [PAYLOAD_BITS-1:0] CR_BYTE = PAYLOAD_BITS'(8'h0D);
  localparam logic [PAYLOAD_BITS-1:0] LF_BYTE = PAYLOAD_BITS'(8'h0A);
  logic [1:0] crlf_q, crlf_d;
`else
  typedef enum logic [2:0] {IDLE, FETCH, START, WAIT_ACK, WAIT_DONE} state_t;
`endif

  state_t                  state_q, state_d;
  logic [2:0]              grant_q, grant_d;
  logic [2:0]              start_q, start_d;
  logic [NUM_REQ-1:0]      ready_q, ready_d;
  logic                    en_q, en_d;
  logic                    busy_q, busy_d;
  logic                    last_q, last_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;

  logic                    hi_hit, lo_hit;
  logic [2:0]              hi_idx, lo_idx, arb_idx;
  logic [PAYLOAD_BITS-1:0] own_data;
  logic                    own_last;
  logic                    accept;
  logic                    release_msg;
  logic [2:0]              next_start;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [2:0] idx);
    onehot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (idx == 3'(j)) onehot[j] = 1'b1;
    end
  endfunction

  // First valid at or above start_q wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_hit = 1'b0;
    lo_idx = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req_valid[j] && !hi_hit && (3'(j) >= start_q)) begin
        hi_hit = 1'b1;
        hi_idx = 3'(j);
      end
      if (req_valid[j] && !lo_hit) begin
        lo_hit = 1'b1;
        lo_idx = 3'(j);
      end
    end
    arb_idx = hi_hit ? hi_idx : lo_idx;
  end

  always_comb begin
    own_data = '0;
    own_last = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_q == 3'(j)) begin
        own_data = req_data[j*PAYLOAD_BITS +: PAYLOAD_BITS];
        own_last = req_last[j];
      end
    end
  end

  assign accept     = |(req_valid & ready_q);
  assign next_start = (grant_q == 3'(NUM_REQ-1)) ? 3'd0 : grant_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    start_d     = start_q;
    ready_d     = '0;
    en_d        = 1'b0;
    busy_d      = busy_q;
    last_d      = last_q;
    data_d      = data_q;
    release_msg = 1'b0;
`ifdef UART_TX_SCHED_CRLF_EN
    crlf_d      = crlf_q;
`endif
    case (state_q)
      // Granting waits for an idle transmitter so a byte abandoned by reset cannot collide.
      IDLE: begin
        if (lo_hit && !uart_tx_busy) begin
          grant_d = arb_idx;
          busy_d  = 1'b1;
          ready_d = onehot(arb_idx);
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (accept) begin
          data_d  = own_data;
          last_d  = own_last;
          en_d    = 1'b1;
          state_d = START;
        end else begin
          ready_d = ready_q;
        end
      end
      START: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (uart_tx_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          if (!last_q) begin
            ready_d = onehot(grant_q);
            state_d = FETCH;
          end else begin
`ifdef UART_TX_SCHED_CRLF_EN
            if (crlf_q == 2'd2) release_msg = 1'b1;
            else                state_d     = TERM;
`else
            release_msg = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TX_SCHED_CRLF_EN
      // crlf_q counts terminator bytes already launched for this message.
      TERM: begin
        if (!uart_tx_busy) begin
          data_d  = (crlf_q == 2'd0) ? CR_BYTE : LF_BYTE;
          crlf_d  = crlf_q + 2'd1;
          en_d    = 1'b1;
          state_d = START;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (release_msg) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      start_d = next_start;
`ifdef UART_TX_SCHED_CRLF_EN
      crlf_d  = 2'd0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      start_q <= '0;
      ready_q <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
`ifdef UART_TX_SCHED_CRLF_EN
      crlf_q  <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      start_q <= start_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      data_q  <= data_d;
`ifdef UART_TX_SCHED_CRLF_EN
      crlf_q  <= crlf_d;
`endif
    end
  end

  assign req_ready    = ready_q;
  assign uart_tx_en   = en_q;
  assign uart_tx_data = data_q;
  assign grant_id     = grant_q;
  assign sched_busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: requester models, a UART busy model and assertion-based checks.
// Honors UART_TX_SCHED_CRLF_EN the same way as the design.
module tb_uart_tx_sched;

`ifdef UART_TX_SCHED_CRLF_EN
  localparam int P = 3;
`else
  localparam int P = 1;
`endif

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic        tx_busy = 1'b0;
  logic [2:0]  grant_id;
  logic        sched_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_en = -100;
  int tx_cnt = 0;

  logic [7:0] mbytes [4][4];
  int         mlen [4];
  int         mpos [4];
  bit         mrep [4];
  bit         mstall [4];

  int         log_gid [$];
  logic [7:0] log_data [$];
  logic       log_sb [$];

  uart_tx_sched #(.NUM_REQ(4), .PAYLOAD_BITS(8)) dut (
    .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .uart_tx_en(uart_tx_en),
    .uart_tx_data(uart_tx_data), .uart_tx_busy(tx_busy), .grant_id(grant_id),
    .sched_busy(sched_busy)
  );

  always #5 CLK = ~CLK;

  // Transmitter: busy rises the cycle after a start pulse and stays high for 11 cycles.
  always @(posedge CLK) begin
    if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_busy <= 1'b0;
    end else if (uart_tx_en) begin
      tx_busy <= 1'b1;
      tx_cnt  <= 11;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh4(input logic [2:0] i);
    oh4 = 4'b0;
    if (i < 3'd4) oh4[i[1:0]] = 1'b1;
  endfunction

  task automatic applyStimulus();
    for (int i = 0; i < 4; i++) begin
      if (mpos[i] < mlen[i] && !mstall[i]) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = mbytes[i][mpos[i]];
        req_last[i]         = (mpos[i] == mlen[i] - 1);
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  // One clock: sample/log at negedge, then advance requesters that handshook at the posedge.
  task automatic tick();
    logic [3:0] rdy;
    logic [3:0] vld;
    @(negedge CLK);
    cyc++;
    if (req_ready != 4'b0) checkOutput("ready_owner", 32'(req_ready), 32'(oh4(grant_id)));
    if (uart_tx_en) begin
      checkOutput("en_while_busy", 32'(tx_busy), 32'd0);
      checkOutput("en_spacing", 32'(cyc - last_en >= 4), 32'd1);
      last_en = cyc;
      log_gid.push_back(int'(grant_id));
      log_data.push_back(uart_tx_data);
      log_sb.push_back(sched_busy);
    end
    rdy = req_ready;
    vld = req_valid;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (vld[i] && rdy[i]) begin
        mpos[i]++;
        if (mpos[i] >= mlen[i] && mrep[i]) mpos[i] = 0;
      end
    end
    applyStimulus();
  endtask

  task automatic run_pulses(input int n, input int maxc, input string tag);
    int c = 0;
    while (log_data.size() < n && c < maxc) begin
      tick();
      c++;
    end
    checkOutput({tag, "_pulses"}, 32'(log_data.size()), 32'(n));
  endtask

  task automatic wait_release(input int maxc, input string tag);
    int c = 0;
    while (sched_busy && c < maxc) begin
      tick();
      c++;
    end
    checkOutput({tag, "_release"}, 32'(sched_busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mlen[i] = 0; mpos[i] = 0; mrep[i] = 1'b0; mstall[i] = 1'b0;
    end
    applyStimulus();
    tick();
    tick();
    reset = 1'b1;
    log_gid.delete();
    log_data.delete();
    log_sb.delete();
    last_en = -100;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'd0);
    checkOutput({tag, "_en"},    32'(uart_tx_en), 32'd0);
    checkOutput({tag, "_data"},  32'(uart_tx_data), 32'd0);
    checkOutput({tag, "_grant"}, 32'(grant_id), 32'd0);
    checkOutput({tag, "_busy"},  32'(sched_busy), 32'd0);
  endtask

  initial begin
    int exp_f [6];
    int c;
    exp_f = '{0, 1, 3, 0, 1, 3};
    applyStimulus();
    do_reset();
    check_reset_values("por");

    // Single two-byte message from requester 2.
    mbytes[2][0] = 8'h41; mbytes[2][1] = 8'h42; mlen[2] = 2;
    applyStimulus();
    run_pulses(2, 100, "single");
    wait_release(200, "single");
    checkOutput("single_total", 32'(log_data.size()), 32'(2 + P - 1));
    checkOutput("single_d0", 32'(log_data[0]), 32'h41);
    checkOutput("single_d1", 32'(log_data[1]), 32'h42);
    checkOutput("single_g0", 32'(log_gid[0]), 32'd2);
    checkOutput("single_g1", 32'(log_gid[1]), 32'd2);
    checkOutput("single_sb1", 32'(log_sb[1]), 32'd1);

    // Contention between requesters 0 and 1 right after reset.
    do_reset();
    mbytes[0][0] = 8'hC0; mlen[0] = 1;
    mbytes[1][0] = 8'hC1; mlen[1] = 1;
    applyStimulus();
    run_pulses(2 * P, 300, "contend");
    checkOutput("contend_g_first", 32'(log_gid[0]), 32'd0);
    checkOutput("contend_d_first", 32'(log_data[0]), 32'hC0);
    checkOutput("contend_g_second", 32'(log_gid[P]), 32'd1);
    checkOutput("contend_d_second", 32'(log_data[P]), 32'hC1);
    wait_release(200, "contend");

    // Fairness: 0, 1 and 3 keep re-presenting single-byte messages.
    do_reset();
    mbytes[0][0] = 8'hA0; mbytes[1][0] = 8'hA1; mbytes[3][0] = 8'hA3;
    mlen[0] = 1; mlen[1] = 1; mlen[3] = 1;
    mrep[0] = 1'b1; mrep[1] = 1'b1; mrep[3] = 1'b1;
    applyStimulus();
    run_pulses(6 * P, 1200, "fair");
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("fair_g%0d", k), 32'(log_gid[k*P]), 32'(exp_f[k]));
    end

    // Owner stalls mid-message, then resumes with its next byte.
    do_reset();
    mbytes[1][0] = 8'h10; mbytes[1][1] = 8'h11; mbytes[1][2] = 8'h12; mlen[1] = 3;
    applyStimulus();
    run_pulses(1, 100, "stall_first");
    mstall[1] = 1'b1;
    applyStimulus();
    repeat (35) tick();
    checkOutput("stall_no_en", 32'(log_data.size()), 32'd1);
    checkOutput("stall_busy", 32'(sched_busy), 32'd1);
    checkOutput("stall_grant", 32'(grant_id), 32'd1);
    checkOutput("stall_ready", 32'(req_ready), 32'b0010);
    mstall[1] = 1'b0;
    applyStimulus();
    run_pulses(3, 200, "stall_resume");
    checkOutput("stall_d1", 32'(log_data[1]), 32'h11);
    checkOutput("stall_d2", 32'(log_data[2]), 32'h12);
    checkOutput("stall_g2", 32'(log_gid[2]), 32'd1);
    wait_release(300, "stall");

    // Reset during WAIT_DONE: pointer would otherwise favour requester 2.
    do_reset();
    mbytes[1][0] = 8'h21; mlen[1] = 1;
    applyStimulus();
    run_pulses(1, 100, "mid_pre");
    wait_release(200, "mid_pre");
    mbytes[2][0] = 8'h31; mbytes[2][1] = 8'h32; mlen[2] = 2;
    applyStimulus();
    run_pulses(P + 1, 200, "mid_first");
    repeat (3) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    mpos[2] = 0;
    mbytes[0][0] = 8'h07; mlen[0] = 1;
    applyStimulus();
    check_reset_values("midrst");
    log_gid.delete();
    log_data.delete();
    log_sb.delete();
    run_pulses(1, 200, "mid_after");
    checkOutput("mid_after_g", 32'(log_gid[0]), 32'd0);
    checkOutput("mid_after_d", 32'(log_data[0]), 32'h07);
    run_pulses(P + 1, 300, "mid_resend");
    checkOutput("mid_resend_g", 32'(log_gid[P]), 32'd2);
    checkOutput("mid_resend_d", 32'(log_data[P]), 32'h31);
    wait_release(400, "mid_resend");

`ifdef UART_TX_SCHED_CRLF_EN
    do_reset();
    mbytes[0][0] = 8'h31; mlen[0] = 1;
    applyStimulus();
    run_pulses(3, 200, "crlf");
    checkOutput("crlf_d0", 32'(log_data[0]), 32'h31);
    checkOutput("crlf_d1", 32'(log_data[1]), 32'h0D);
    checkOutput("crlf_d2", 32'(log_data[2]), 32'h0A);
    checkOutput("crlf_sb2", 32'(log_sb[2]), 32'd1);
    c = 0;
    while (tx_busy && c < 50) begin
      tick();
      c++;
    end
    checkOutput("crlf_busy_hold", 32'(sched_busy), 32'd1);
    wait_release(20, "crlf");
`endif
    c = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
